// File: rtl/llsc_link_ctrl_pkg.sv
// Shared constants and types for the LL/SC link controller.
// Holds default geometry, the link state encoding and common enable levels.
package llsc_link_ctrl_pkg;

    localparam int LLSC_ADDR_W   = 32;
    localparam int LLSC_GRAN_LSB = 2;
    localparam int LLSC_TIMEOUT  = 1024;

    // The link state is the architectural LLbit itself.
    typedef enum logic {
        LINK_IDLE   = 1'b0,
        LINK_LINKED = 1'b1
    } link_state_e;

    localparam logic RST_ENA   = 1'b1;
    localparam logic WRITE_ENA = 1'b1;
    localparam logic WRITE_DIS = 1'b0;

    function automatic int timer_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/llsc_link_timer.sv
// Saturating link-lifetime counter: clear has priority, counts while enabled,
// and flags expiry on the last allowed cycle. LIMIT of 0 never expires.
module llsc_link_timer
    import llsc_link_ctrl_pkg::*;
#(
    parameter int LIMIT = LLSC_TIMEOUT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire_o
);

    localparam int CW = timer_width(LIMIT);
    localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst == RST_ENA || clr) begin
            count_q <= '0;
        end else if (en && count_q != LAST) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign expire_o = (LIMIT > 0) && en && (count_q == LAST);

endmodule

// File: rtl/llsc_link_ctrl.sv
// LL/SC link controller: resolves SC success in MEM with WB-slot forwarding,
// commits the link one cycle later and drops it on snoop hit, flush or timeout.
module llsc_link_ctrl
    import llsc_link_ctrl_pkg::*;
#(
    parameter int ADDR_W       = LLSC_ADDR_W,
    parameter int GRAN_LSB     = LLSC_GRAN_LSB,
    parameter int LINK_TIMEOUT = LLSC_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              mem_ll_i,
    input  logic              mem_sc_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic              snoop_we_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              sc_success_o,
    output logic              llbit_o,
    output logic [ADDR_W-1:0] link_addr_o
);

    localparam logic [ADDR_W-1:0] GRAN_MASK = {ADDR_W{1'b1}} << GRAN_LSB;

    function automatic logic addr_match(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return ((a ^ b) & GRAN_MASK) == '0;
    endfunction

    // WB-stage slot holding the not-yet-committed link update.
    logic              pend_we;
    logic              pend_bit;
    logic [ADDR_W-1:0] pend_addr;

    logic [ADDR_W-1:0] link_addr_q;
    link_state_e       state_q, state_d;

    logic              slot_load;
    logic              eff_bit;
    logic [ADDR_W-1:0] eff_addr;
    logic              sc_snoop_hit;
    logic              ll_snoop_hit;
    logic              pend_snoop_hit;
    logic              link_snoop_hit;
    logic              timer_clr;
    logic              timer_en;
    logic              timer_expire;

    assign slot_load      = !stall_i && !flush_i && (mem_ll_i || mem_sc_i);
    assign eff_bit        = pend_we ? pend_bit  : llbit_o;
    assign eff_addr       = pend_we ? pend_addr : link_addr_q;
    assign sc_snoop_hit   = snoop_we_i && addr_match(snoop_addr_i, eff_addr);
    assign ll_snoop_hit   = snoop_we_i && addr_match(snoop_addr_i, mem_addr_i);
    assign pend_snoop_hit = snoop_we_i && addr_match(snoop_addr_i, pend_addr);
    assign link_snoop_hit = snoop_we_i && addr_match(snoop_addr_i, link_addr_q);

    // Reset gating keeps the combinational result quiet while state is being cleared.
    assign sc_success_o = (rst != RST_ENA) && mem_sc_i && !stall_i && !flush_i &&
                          eff_bit && addr_match(eff_addr, mem_addr_i) && !sc_snoop_hit;

    // An SC re-writes the current link address so its commit only clears the bit.
    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            pend_we   <= WRITE_DIS;
            pend_bit  <= 1'b0;
            pend_addr <= '0;
        end else if (flush_i) begin
            pend_we   <= WRITE_DIS;
            pend_bit  <= 1'b0;
        end else if (slot_load) begin
            pend_we   <= WRITE_ENA;
            pend_bit  <= mem_ll_i && !ll_snoop_hit;
            pend_addr <= mem_ll_i ? (mem_addr_i & GRAN_MASK) : eff_addr;
        end else begin
            pend_we   <= WRITE_DIS;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            link_addr_q <= '0;
        end else if (!flush_i && pend_we == WRITE_ENA) begin
            link_addr_q <= pend_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENA) begin
            state_q <= LINK_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Priority: flush, then slot commit, then snoop/timeout on the committed link.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = LINK_IDLE;
        end else if (pend_we == WRITE_ENA) begin
            state_d = (pend_bit && !pend_snoop_hit) ? LINK_LINKED : LINK_IDLE;
        end else if (state_q == LINK_LINKED && (link_snoop_hit || timer_expire)) begin
            state_d = LINK_IDLE;
        end
    end

    assign timer_clr = flush_i || (pend_we && pend_bit);
    assign timer_en  = (state_q == LINK_LINKED);

    llsc_link_timer #(
        .LIMIT (LINK_TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .clr      (timer_clr),
        .en       (timer_en),
        .expire_o (timer_expire)
    );

    assign llbit_o     = (state_q == LINK_LINKED);
    assign link_addr_o = link_addr_q;

endmodule

// File: tb/tb_llsc_link_ctrl.sv
// Bench for llsc_link_ctrl: directed scenarios plus randomized traffic checked
// against a word-level link model with an in-flight update queue.
module tb_llsc_link_ctrl;

    localparam int ADDR_W   = 32;
    localparam int GRAN_LSB = 2;
    localparam int TMO      = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall_i, flush_i, mem_ll_i, mem_sc_i, snoop_we_i;
    logic [ADDR_W-1:0] mem_addr_i, snoop_addr_i;
    logic              sc_success_o, llbit_o;
    logic [ADDR_W-1:0] link_addr_o;

    llsc_link_ctrl #(
        .ADDR_W       (ADDR_W),
        .GRAN_LSB     (GRAN_LSB),
        .LINK_TIMEOUT (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .mem_ll_i     (mem_ll_i),
        .mem_sc_i     (mem_sc_i),
        .mem_addr_i   (mem_addr_i),
        .snoop_we_i   (snoop_we_i),
        .snoop_addr_i (snoop_addr_i),
        .sc_success_o (sc_success_o),
        .llbit_o      (llbit_o),
        .link_addr_o  (link_addr_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Stimulus for the next cycle, and what was seen / expected in it.
    logic              d_rst, d_stall, d_flush, d_ll, d_sc, d_swe;
    logic [ADDR_W-1:0] d_addr, d_saddr;
    logic              o_sc, o_bit, e_sc, e_bit;
    logic [ADDR_W-1:0] o_addr, e_addr;

    // ---------------- reference model ----------------
    // Link kept as a word index; updates accepted in MEM land one cycle later.
    typedef struct {
        bit          is_ll;
        bit          lbit;
        int unsigned word;
    } upd_t;

    upd_t        inflight[$];
    bit          m_bit  = 1'b0;
    int unsigned m_word = 0;
    int          m_age  = 0;

    task automatic model_cycle();
        upd_t        u;
        bit          cb;
        int unsigned cw, aw, sw;
        bit          snoop_any;
        aw = d_addr >> GRAN_LSB;
        sw = d_saddr >> GRAN_LSB;
        snoop_any = d_swe;
        if (inflight.size() > 0) begin
            cb = inflight[0].lbit;
            cw = inflight[0].word;
        end else begin
            cb = m_bit;
            cw = m_word;
        end
        e_bit  = m_bit;
        e_addr = m_word << GRAN_LSB;
        e_sc   = !d_rst && d_sc && !d_stall && !d_flush && cb && (cw == aw) &&
                 !(snoop_any && sw == cw);
        if (d_rst) begin
            inflight.delete();
            m_bit  = 1'b0;
            m_word = 0;
            m_age  = 0;
        end else if (d_flush) begin
            inflight.delete();
            m_bit = 1'b0;
        end else begin
            if (inflight.size() > 0) begin
                u      = inflight.pop_front();
                m_word = u.word;
                m_bit  = u.lbit && !(snoop_any && sw == u.word);
                if (u.is_ll) m_age = 0;
            end else if (m_bit) begin
                if (snoop_any && sw == m_word) m_bit = 1'b0;
                else if (m_age == TMO - 1)      m_bit = 1'b0;
                else                            m_age++;
            end
            if (!d_stall && d_ll) begin
                u.is_ll = 1'b1;
                u.lbit  = !(snoop_any && sw == aw);
                u.word  = aw;
                inflight.push_back(u);
            end else if (!d_stall && d_sc) begin
                u.is_ll = 1'b0;
                u.lbit  = 1'b0;
                u.word  = cw;
                inflight.push_back(u);
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic set_idle();
        d_rst   = 1'b0;
        d_stall = 1'b0;
        d_flush = 1'b0;
        d_ll    = 1'b0;
        d_sc    = 1'b0;
        d_swe   = 1'b0;
        d_addr  = '0;
        d_saddr = '0;
    endtask

    // Drive one cycle on the falling edge, sample outputs before the rising edge.
    task automatic step();
        @(negedge clk);
        rst          = d_rst;
        stall_i      = d_stall;
        flush_i      = d_flush;
        mem_ll_i     = d_ll;
        mem_sc_i     = d_sc;
        mem_addr_i   = d_addr;
        snoop_we_i   = d_swe;
        snoop_addr_i = d_saddr;
        #1;
        o_sc   = sc_success_o;
        o_bit  = llbit_o;
        o_addr = link_addr_o;
        model_cycle();
    endtask

    task automatic do_reset();
        set_idle();
        d_rst = 1'b1;
        step();
        set_idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        d_rst = 1'b1; d_sc = 1'b1; d_addr = 32'h100;
        step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL reset_sc: got %0b expected 0", o_sc); end
        set_idle();
        step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL reset_llbit: got %0b expected 0", o_bit); end
        n_checks++;
        if (o_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %0h expected 0", o_addr); end
    endtask

    task automatic test_ll_sc_forward();
        do_reset();
        d_ll = 1'b1; d_addr = 32'h100; step();
        set_idle(); d_sc = 1'b1; d_addr = 32'h100; step();
        n_checks++;
        if (o_sc !== 1'b1) begin n_fail++; $display("FAIL fwd_sc: got %0b expected 1", o_sc); end
        set_idle(); step();
        n_checks++;
        if (o_bit !== 1'b1) begin n_fail++; $display("FAIL fwd_llbit_set: got %0b expected 1", o_bit); end
        n_checks++;
        if (o_addr !== 32'h100) begin n_fail++; $display("FAIL fwd_addr: got %0h expected 100", o_addr); end
        step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL fwd_llbit_clr: got %0b expected 0", o_bit); end
    endtask

    task automatic test_snoop();
        do_reset();
        d_ll = 1'b1; d_addr = 32'h100; step();
        set_idle(); d_swe = 1'b1; d_saddr = 32'h102; step();
        set_idle(); d_sc = 1'b1; d_addr = 32'h100; step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL snoop_pend_sc: got %0b expected 0", o_sc); end
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL snoop_pend_llbit: got %0b expected 0", o_bit); end
        // same-cycle snoop kills an otherwise good SC on a committed link
        do_reset();
        d_ll = 1'b1; d_addr = 32'h200; step();
        set_idle(); step(); step();
        d_sc = 1'b1; d_addr = 32'h200; d_swe = 1'b1; d_saddr = 32'h203; step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL snoop_same_cycle_sc: got %0b expected 0", o_sc); end
        // LL together with a matching snoop: link never becomes valid
        do_reset();
        d_ll = 1'b1; d_addr = 32'h300; d_swe = 1'b1; d_saddr = 32'h301; step();
        set_idle(); step(); step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL snoop_ll_race: got %0b expected 0", o_bit); end
        // snoop to a different word leaves the link alone
        do_reset();
        d_ll = 1'b1; d_addr = 32'h300; step();
        set_idle(); d_swe = 1'b1; d_saddr = 32'h304; step();
        set_idle(); d_sc = 1'b1; d_addr = 32'h300; step();
        n_checks++;
        if (o_sc !== 1'b1) begin n_fail++; $display("FAIL snoop_other_word: got %0b expected 1", o_sc); end
    endtask

    task automatic test_addr_match();
        do_reset();
        d_ll = 1'b1; d_addr = 32'h100; step();
        set_idle(); d_sc = 1'b1; d_addr = 32'h104; step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL mismatch_sc: got %0b expected 0", o_sc); end
        set_idle(); step(); step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL mismatch_llbit: got %0b expected 0", o_bit); end
        do_reset();
        d_ll = 1'b1; d_addr = 32'h101; step();
        set_idle(); step();
        d_sc = 1'b1; d_addr = 32'h103; step();
        n_checks++;
        if (o_sc !== 1'b1) begin n_fail++; $display("FAIL same_word_sc: got %0b expected 1", o_sc); end
        n_checks++;
        if (o_addr !== 32'h100) begin n_fail++; $display("FAIL addr_gran: got %0h expected 100", o_addr); end
    endtask

    task automatic test_flush();
        do_reset();
        d_ll = 1'b1; d_addr = 32'h200; step();
        set_idle(); step(); step();
        d_ll = 1'b1; d_addr = 32'h300; step();
        set_idle(); d_flush = 1'b1; d_sc = 1'b1; d_addr = 32'h300; step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL flush_sc: got %0b expected 0", o_sc); end
        set_idle(); step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL flush_llbit: got %0b expected 0", o_bit); end
        n_checks++;
        if (o_addr !== 32'h200) begin n_fail++; $display("FAIL flush_addr_kept: got %0h expected 200", o_addr); end
        step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL flush_pend_dropped: got %0b expected 0", o_bit); end
    endtask

    task automatic test_timeout();
        int  high_cnt;
        bit  seen_high;
        bit  done;
        do_reset();
        d_ll = 1'b1; d_addr = 32'h40; step();
        set_idle();
        high_cnt  = 0;
        seen_high = 1'b0;
        done      = 1'b0;
        for (int i = 0; i < 4 * TMO && !done; i++) begin
            step();
            if (o_bit) begin
                high_cnt++;
                seen_high = 1'b1;
            end else if (seen_high) begin
                done = 1'b1;
            end
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL timeout_expired: got no clear within %0d cycles", 4 * TMO); end
        n_checks++;
        if (high_cnt != TMO) begin n_fail++; $display("FAIL timeout_len: got %0d cycles expected %0d", high_cnt, TMO); end
        d_sc = 1'b1; d_addr = 32'h40; step();
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL timeout_sc: got %0b expected 0", o_sc); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            d_stall = 1'b1; d_ll = 1'b1; d_addr = 32'h500; step();
        end
        d_stall = 1'b0; step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL stall_no_load: got %0b expected 0", o_bit); end
        set_idle(); step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL stall_pend: got %0b expected 0", o_bit); end
        d_stall = 1'b1; d_sc = 1'b1; d_addr = 32'h500; step();
        n_checks++;
        if (o_bit !== 1'b1) begin n_fail++; $display("FAIL stall_commit: got %0b expected 1", o_bit); end
        n_checks++;
        if (o_sc !== 1'b0) begin n_fail++; $display("FAIL stall_sc: got %0b expected 0", o_sc); end
        set_idle(); step();
        n_checks++;
        if (o_bit !== 1'b1) begin n_fail++; $display("FAIL stall_sc_no_load: got %0b expected 1", o_bit); end
    endtask

    task automatic test_reset_mid_link();
        do_reset();
        d_ll = 1'b1; d_addr = 32'h180; step();
        set_idle(); d_ll = 1'b1; d_addr = 32'h1c0; step();
        set_idle(); d_rst = 1'b1; step();
        n_checks++;
        if (o_bit !== 1'b1) begin n_fail++; $display("FAIL mid_link_pre: got %0b expected 1", o_bit); end
        set_idle(); step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL mid_link_llbit: got %0b expected 0", o_bit); end
        n_checks++;
        if (o_addr !== 32'h0) begin n_fail++; $display("FAIL mid_link_addr: got %0h expected 0", o_addr); end
        step();
        n_checks++;
        if (o_bit !== 1'b0) begin n_fail++; $display("FAIL mid_link_pend: got %0b expected 0", o_bit); end
    endtask

    task automatic test_random();
        int op;
        int ll_w;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            ll_w    = ((i / 150) % 2 == 0) ? 30 : 4;
            d_rst   = ($urandom_range(0, 399) == 0);
            d_stall = ($urandom_range(0, 4) == 0);
            d_flush = ($urandom_range(0, 24) == 0);
            op      = $urandom_range(0, 99);
            d_ll    = (op < ll_w);
            d_sc    = (op >= ll_w) && (op < ll_w + 25);
            d_addr  = 32'h100 + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            d_swe   = ($urandom_range(0, 9) == 0);
            d_saddr = 32'h100 + ($urandom_range(0, 4) << 2) + $urandom_range(0, 3);
            step();
            n_checks++;
            if (o_sc !== e_sc) begin n_fail++; $display("FAIL rand_sc[%0d]: got %0b expected %0b", i, o_sc, e_sc); end
            n_checks++;
            if (o_bit !== e_bit) begin n_fail++; $display("FAIL rand_llbit[%0d]: got %0b expected %0b", i, o_bit, e_bit); end
            n_checks++;
            if (o_addr !== e_addr) begin n_fail++; $display("FAIL rand_addr[%0d]: got %0h expected %0h", i, o_addr, e_addr); end
        end
        set_idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        set_idle();
        d_rst        = 1'b1;
        rst          = 1'b1;
        stall_i      = 1'b0;
        flush_i      = 1'b0;
        mem_ll_i     = 1'b0;
        mem_sc_i     = 1'b0;
        mem_addr_i   = '0;
        snoop_we_i   = 1'b0;
        snoop_addr_i = '0;
        test_reset();
        test_ll_sc_forward();
        test_snoop();
        test_addr_match();
        test_flush();
        test_timeout();
        test_stall();
        test_reset_mid_link();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
